dm_access_arbiter: RTL and testbench

- Sits between the data memory port and a single-port, word-wide, byte-enable-free data RAM.
- Arbitrates between two requesters:
  - cpu: the MIPS core's load/store path (lw/lh/lhu/lb/lbu, sw/sh/sb).
  - dbg: a debug/loader port used by benches to preload or dump memory.
- Sequences sub-word stores as read-modify-write.
- Extracts and sign/zero-extends sub-word loads.

---
 rtl/dm_pkg.sv | 30 +++
 rtl/dm_lane_unit.sv | 59 +++++
 rtl/dm_access_arbiter.sv | 158 +++++++++++++++
 tb/tb_dm_access_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory access arbiter:
// access size codes, FSM state type and grant ids.
package dm_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RDW,
    S_WR,
    S_ERR
  } state_t;

  localparam logic GNT_CPU = 1'b0;
  localparam logic GNT_DBG = 1'b1;

  // Alignment / size legality of a request.
  function automatic logic bad_shape(
    input logic [1:0] size,
    input logic [1:0] lo
  );
    return (size == 2'd3) ||
           (size == SZ_H && lo[0]) ||
           (size == SZ_W && lo != 2'b00);
  endfunction

endpackage

// File: rtl/dm_lane_unit.sv
// Little-endian lane logic: load extract/extend and store merge.
// Ports: rword/lo/size/sext -> ldata; rword/nword/lo/size -> mword.
import dm_pkg::*;

module dm_lane_unit (
  input  logic [31:0] rword,
  input  logic [31:0] nword,
  input  logic [1:0]  lo,
  input  logic [1:0]  size,
  input  logic        sext,
  output logic [31:0] ldata,
  output logic [31:0] mword
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = 8'h00;
    unique case (lo)
      2'd0: b = rword[7:0];
      2'd1: b = rword[15:8];
      2'd2: b = rword[23:16];
      2'd3: b = rword[31:24];
    endcase
    h = lo[1] ? rword[31:16] : rword[15:0];
  end

  always_comb begin
    ldata = rword;
    unique case (1'b1)
      (size == SZ_B): ldata = {{24{sext & b[7]}}, b};
      (size == SZ_H): ldata = {{16{sext & h[15]}}, h};
      default:        ldata = rword;
    endcase
  end

  always_comb begin
    mword = rword;
    unique case (1'b1)
      (size == SZ_B): begin
        unique case (lo)
          2'd0: mword[7:0]   = nword[7:0];
          2'd1: mword[15:8]  = nword[7:0];
          2'd2: mword[23:16] = nword[7:0];
          2'd3: mword[31:24] = nword[7:0];
        endcase
      end
      (size == SZ_H): begin
        if (lo[1])
          mword[31:16] = nword[15:0];
        else
          mword[15:0] = nword[15:0];
      end
      default: mword = nword;
    endcase
  end

endmodule

// File: rtl/dm_access_arbiter.sv
// Round-robin cpu/dbg arbiter onto a word RAM with sub-word RMW.
// Ports: cpu_*/dbg_* request/ack sides, ram_* RAM side, busy.
import dm_pkg::*;

module dm_access_arbiter #(
  parameter logic [31:0] DATA_BASE = 32'h0000_0000,
  parameter int          RAM_AW    = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [1:0]        cpu_size,
  input  logic              cpu_sext,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_ack,
  output logic              cpu_err,
  output logic [31:0]       cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [1:0]        dbg_size,
  input  logic              dbg_sext,
  input  logic [31:0]       dbg_addr,
  input  logic [31:0]       dbg_wdata,
  output logic              dbg_ack,
  output logic              dbg_err,
  output logic [31:0]       dbg_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic              busy
);

  state_t            st;
  logic              gid;
  logic              last;
  logic              we_q;
  logic              sext_q;
  logic [1:0]        size_q;
  logic [1:0]        lo_q;
  logic [RAM_AW-1:0] idx_q;
  logic [31:0]       wbuf;

  logic              pick;
  logic              s_we;
  logic              s_sext;
  logic [1:0]        s_size;
  logic [31:0]       s_addr;
  logic [31:0]       s_wdata;
  logic [29:0]       off_w;
  logic              bad;
  logic [31:0]       ldata;
  logic [31:0]       mword;
  logic              done;
  logic              ld_done;

  // On a tie the port not granted last wins.
  assign pick = (cpu_req && dbg_req) ? ~last : ~cpu_req;

  always_comb begin
    if (pick == GNT_DBG) begin
      s_we    = dbg_we;
      s_size  = dbg_size;
      s_sext  = dbg_sext;
      s_addr  = dbg_addr;
      s_wdata = dbg_wdata;
    end else begin
      s_we    = cpu_we;
      s_size  = cpu_size;
      s_sext  = cpu_sext;
      s_addr  = cpu_addr;
      s_wdata = cpu_wdata;
    end
  end

  // Word offset; any bit above RAM_AW means out of range.
  assign off_w = s_addr[31:2] - DATA_BASE[31:2];
  assign bad   = bad_shape(s_size, s_addr[1:0]) ||
                 (|off_w[29:RAM_AW]);

  dm_lane_unit u_lane (
    .rword (ram_rdata),
    .nword (wbuf),
    .lo    (lo_q),
    .size  (size_q),
    .sext  (sext_q),
    .ldata (ldata),
    .mword (mword)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st     <= S_IDLE;
      gid    <= GNT_CPU;
      last   <= GNT_DBG;
      we_q   <= 1'b0;
      sext_q <= 1'b0;
      size_q <= SZ_W;
      lo_q   <= 2'b00;
      idx_q  <= '0;
      wbuf   <= 32'h0;
    end else begin
      unique case (st)
        S_IDLE: begin
          if (cpu_req || dbg_req) begin
            gid    <= pick;
            last   <= pick;
            we_q   <= s_we;
            sext_q <= s_sext;
            size_q <= s_size;
            lo_q   <= s_addr[1:0];
            idx_q  <= off_w[RAM_AW-1:0];
            wbuf   <= s_wdata;
            if (bad)
              st <= S_ERR;
            else if (s_we && s_size == SZ_W)
              st <= S_WR;
            else
              st <= S_RD;
          end
        end
        S_RD: st <= S_RDW;
        S_RDW: begin
          if (we_q) begin
            wbuf <= mword;
            st   <= S_WR;
          end else begin
            st <= S_IDLE;
          end
        end
        S_WR:    st <= S_IDLE;
        S_ERR:   st <= S_IDLE;
        default: st <= S_IDLE;
      endcase
    end
  end

  // RAM strobes decode from state so reset kills a pending write.
  assign ram_en    = (st == S_RD) || (st == S_WR);
  assign ram_we    = (st == S_WR);
  assign ram_addr  = idx_q;
  assign ram_wdata = wbuf;
  assign busy      = (st != S_IDLE);

  assign ld_done = (st == S_RDW) && !we_q;
  assign done    = (st == S_WR) || (st == S_ERR) || ld_done;

  assign cpu_ack   = done && (gid == GNT_CPU);
  assign dbg_ack   = done && (gid == GNT_DBG);
  assign cpu_err   = cpu_ack && (st == S_ERR);
  assign dbg_err   = dbg_ack && (st == S_ERR);
  assign cpu_rdata = (ld_done && gid == GNT_CPU) ? ldata : 32'h0;
  assign dbg_rdata = (ld_done && gid == GNT_DBG) ? ldata : 32'h0;

endmodule

// File: tb/tb_dm_access_arbiter.sv
// Self-checking bench for dm_access_arbiter against a byte-array
// memory model, with a synchronous RAM model on the RAM port.
module tb_dm_access_arbiter;

  localparam int          AW   = 10;
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cpu_req = 1'b0, cpu_we = 1'b0, cpu_sext = 1'b0;
  logic [1:0]    cpu_size = 2'd2;
  logic [31:0]   cpu_addr = 32'h0, cpu_wdata = 32'h0;
  logic          cpu_ack, cpu_err;
  logic [31:0]   cpu_rdata;
  logic          dbg_req = 1'b0, dbg_we = 1'b0, dbg_sext = 1'b0;
  logic [1:0]    dbg_size = 2'd2;
  logic [31:0]   dbg_addr = 32'h0, dbg_wdata = 32'h0;
  logic          dbg_ack, dbg_err;
  logic [31:0]   dbg_rdata;
  logic          ram_en, ram_we, busy;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata = 32'h0;

  logic [31:0] ram   [1024] = '{default: 32'h0};
  logic [7:0]  ref_b [4096] = '{default: 8'h00};

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  bit model_last = 1'b1;

  always #5 clk = ~clk;

  dm_access_arbiter #(.DATA_BASE(BASE), .RAM_AW(AW)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size),
    .cpu_sext(cpu_sext), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_size(dbg_size),
    .dbg_sext(dbg_sext), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_err(dbg_err), .dbg_rdata(dbg_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy)
  );

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) ram[ram_addr] <= ram_wdata;
      else        ram_rdata <= ram[ram_addr];
    end
    if (ram_en && ram_we) we_cnt <= we_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_err(input logic [1:0] sz,
                                 input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return (sz == 2'd3) || (sz == 2'd1 && a[0]) ||
           (sz == 2'd2 && a[1:0] != 2'b00) || (off >= (32'd4 << AW));
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a,
                                           input logic [1:0] sz,
                                           input bit sx);
    int nb;
    logic [31:0] v, m;
    nb = 1 << sz;
    v = 32'h0;
    for (int i = 0; i < nb; i++)
      v[8*i +: 8] = ref_b[a - BASE + i];
    m = (nb == 1) ? 32'hFF : (nb == 2) ? 32'hFFFF : 32'hFFFF_FFFF;
    if (sx && nb < 4 && v[8*nb-1]) v = v | ~m;
    return v;
  endfunction

  function automatic logic [31:0] ref_word(input int w);
    return {ref_b[4*w+3], ref_b[4*w+2], ref_b[4*w+1], ref_b[4*w]};
  endfunction

  task automatic drive(input bit p, input bit rq, input bit we,
                       input logic [1:0] sz, input bit sx,
                       input logic [31:0] a, input logic [31:0] wd);
    if (p) begin
      dbg_req = rq; dbg_we = we; dbg_size = sz;
      dbg_sext = sx; dbg_addr = a; dbg_wdata = wd;
    end else begin
      cpu_req = rq; cpu_we = we; cpu_size = sz;
      cpu_sext = sx; cpu_addr = a; cpu_wdata = wd;
    end
  endtask

  // One transaction from an idle DUT; called at a negedge.
  task automatic access(input bit p, input bit we, input logic [1:0] sz,
                        input bit sx, input logic [31:0] a,
                        input logic [31:0] wd, input string tag);
    bit e, got, en_seen;
    int lat, n, w;
    logic [31:0] ev, rd, ord;
    logic er, oack;
    e   = exp_err(sz, a);
    lat = e ? 1 : (!we ? 2 : (sz == 2'd2 ? 1 : 3));
    ev  = (!e && !we) ? ref_load(a, sz, sx) : 32'h0;
    drive(p, 1'b1, we, sz, sx, a, wd);
    n = 0; got = 0; en_seen = 0;
    rd = 32'h0; ord = 32'h0; er = 1'b0; oack = 1'b0;
    while (!got && n < 20) begin
      @(posedge clk); @(negedge clk); n++;
      if (ram_en) en_seen = 1;
      if (p ? dbg_ack : cpu_ack) begin
        got  = 1;
        rd   = p ? dbg_rdata : cpu_rdata;
        er   = p ? dbg_err : cpu_err;
        ord  = p ? cpu_rdata : dbg_rdata;
        oack = p ? cpu_ack : dbg_ack;
      end else if (n == 1) begin
        drive(p, 1'b1, 1'($urandom), 2'($urandom), 1'($urandom),
              $urandom, $urandom);
      end
    end
    chk({tag, "_ack"}, 32'(got), 32'd1);
    if (got) begin
      chk({tag, "_lat"}, n, lat);
      chk({tag, "_err"}, 32'(er), 32'(e));
      chk({tag, "_rdata"}, rd, ev);
      chk({tag, "_other_ack"}, 32'(oack), 32'd0);
      chk({tag, "_other_rdata"}, ord, 32'h0);
      if (e) chk({tag, "_no_ram"}, 32'(en_seen), 32'd0);
    end
    if (!e && we)
      for (int i = 0; i < (1 << sz); i++)
        ref_b[a - BASE + i] = wd[8*i +: 8];
    drive(p, 1'b0, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
    @(posedge clk); @(negedge clk);
    if (!e && we) begin
      w = int'((a - BASE) >> 2);
      chk({tag, "_mem"}, ram[w], ref_word(w));
    end
    model_last = p;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_ram"}, {30'd0, ram_en, ram_we}, 32'd0);
    chk({tag, "_acks"}, {28'd0, cpu_ack, cpu_err, dbg_ack, dbg_err}, 32'd0);
    chk({tag, "_rdata"}, cpu_rdata | dbg_rdata, 32'h0);
  endtask

  initial begin
    int wc, cnt, cyc;
    bit owner, eo;
    logic [31:0] a, ca, da;
    logic [1:0] sz;

    #2;
    reset_checks("reset");
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    access(0, 1, 2'd2, 0, 32'h4, 32'h1234_5678, "sw4");
    access(0, 0, 2'd2, 0, 32'h4, 32'h0, "lw4");
    access(0, 1, 2'd0, 0, 32'h5, 32'h0000_00AB, "sb5");
    chk("sb5_word", ram[1], 32'h1234_AB78);
    access(0, 0, 2'd0, 1, 32'h5, 32'h0, "lb5");
    access(0, 0, 2'd0, 0, 32'h5, 32'h0, "lbu5");
    access(0, 1, 2'd1, 0, 32'h6, 32'h0000_8001, "sh6");
    chk("sh6_word", ram[1], 32'h8001_AB78);
    access(0, 0, 2'd1, 1, 32'h6, 32'h0, "lh6");
    access(0, 0, 2'd1, 0, 32'h6, 32'h0, "lhu6");
    access(0, 0, 2'd2, 0, 32'h2, 32'h0, "lw2");
    access(0, 1, 2'd1, 0, 32'h3, 32'h5555, "sh3");
    access(1, 0, 2'd2, 0, 32'h1000, 32'h0, "lw1000");
    access(0, 0, 2'd3, 0, 32'h8, 32'h0, "size3");

    // Reset while a dbg byte store sits in its read-wait cycle.
    wc = we_cnt;
    drive(1, 1'b1, 1'b1, 2'd0, 1'b0, 32'h5, 32'h0000_00CD);
    @(posedge clk); @(negedge clk);
    chk("rmw_busy_rd", 32'(busy), 32'd1);
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    drive(1, 1'b0, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
    #1;
    reset_checks("midreset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_last = 1'b1;
    @(negedge clk);
    chk("midreset_we", we_cnt, wc);
    chk("midreset_word", ram[1], ref_word(1));

    // Both requesters held for six transactions.
    ca = 32'h4; da = 32'h5;
    drive(0, 1'b1, 1'b0, 2'd2, 1'b0, ca, 32'h0);
    drive(1, 1'b1, 1'b0, 2'd0, 1'b1, da, 32'h0);
    cnt = 0; cyc = 0;
    while (cnt < 6 && cyc < 60) begin
      @(posedge clk); @(negedge clk); cyc++;
      if (cpu_ack || dbg_ack) begin
        owner = dbg_ack;
        eo = ~model_last;
        chk("arb_single", 32'(cpu_ack & dbg_ack), 32'd0);
        chk("arb_order", 32'(owner), 32'(eo));
        if (owner) begin
          chk("arb_dbg_rdata", dbg_rdata, ref_load(da, 2'd0, 1'b1));
          chk("arb_cpu_idle", cpu_rdata, 32'h0);
        end else begin
          chk("arb_cpu_rdata", cpu_rdata, ref_load(ca, 2'd2, 1'b0));
          chk("arb_dbg_idle", dbg_rdata, 32'h0);
        end
        model_last = owner;
        cnt++;
      end
    end
    chk("arb_count", cnt, 6);
    cpu_req = 1'b0; dbg_req = 1'b0;
    @(posedge clk); @(negedge clk);
    if (busy) begin
      @(posedge clk); @(negedge clk);
      @(posedge clk); @(negedge clk);
    end

    // Random mix against the byte model.
    for (int i = 0; i < 40; i++) begin
      sz = ($urandom % 8 == 7) ? 2'd3 : 2'($urandom % 3);
      a  = ($urandom % 10 == 0) ? 32'h1000 + ($urandom % 16)
                                : 32'($urandom % 64);
      access(1'($urandom), 1'($urandom), sz, 1'($urandom), a,
             $urandom, "rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
